// File: rtl/dds_pkg.sv
// Shared DDS types: period_meter FSM states and the default counter width
// used by both the phase accumulator and the period meter.
package dds_pkg;

    localparam int unsigned DdsWidth = 12;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas,
        StDone
    } pm_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures the rising-edge period of an asynchronous input, averages 2^AVG_SHIFT periods
// and reports mean period minus 1, ready to use as a phase accumulator wrap value.
module period_meter
    import dds_pkg::*;
#(
    parameter int unsigned WIDE_N    = DdsWidth,
    parameter int unsigned AVG_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_i,
    input  logic              start_i,
    output logic [WIDE_N-1:0] period_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam int unsigned AccW  = WIDE_N + AVG_SHIFT;
    localparam int unsigned NperW = AVG_SHIFT + 1;
    localparam logic [NperW-1:0] NperLast = NperW'((1 << AVG_SHIFT) - 1);

    logic              rise;
    pm_state_e         state_q;
    logic [WIDE_N-1:0] pcnt_q;
    logic [AccW-1:0]   acc_q;
    logic [NperW-1:0]  nper_q;

    sync_edge u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig_i),
        .rise_o (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pcnt_q   <= '0;
            acc_q    <= '0;
            nper_q   <= '0;
            period_o <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            // pcnt holds N-1 whenever a rise is present
            pcnt_q  <= rise ? '0 : pcnt_q + WIDE_N'(1);
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StArm;
                        acc_q   <= '0;
                        nper_q  <= '0;
                        ovf_o   <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                StArm: begin
                    if (rise) begin
                        state_q <= StMeas;
                    end
                end
                StMeas: begin
                    // A rise on the all-ones count still wins, so N = 2^WIDE_N is measurable
                    if (rise) begin
                        acc_q  <= acc_q + AccW'(pcnt_q);
                        nper_q <= nper_q + NperW'(1);
                        if (nper_q == NperLast) begin
                            state_q <= StDone;
                            busy_o  <= 1'b0;
                        end
                    end else if (&pcnt_q) begin
                        state_q <= StIdle;
                        ovf_o   <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                StDone: begin
                    period_o <= WIDE_N'(acc_q >> AVG_SHIFT);
                    valid_o  <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed bench for period_meter against a mean-of-periods reference model.
module tb_period_meter;

    localparam int unsigned WIDE_N    = 12;
    localparam int unsigned AVG_SHIFT = 2;
    localparam int          NAVG      = 1 << AVG_SHIFT;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              sig_i   = 1'b0;
    logic              start_i = 1'b0;
    logic [WIDE_N-1:0] period_o;
    logic              valid_o;
    logic              busy_o;
    logic              ovf_o;

    int vectors     = 0;
    int miscompares = 0;

    int                cyc           = 0;
    int                valid_cnt     = 0;
    int                valid_cyc     = -1;
    logic [WIDE_N-1:0] valid_val     = '0;
    int                ovf_cyc       = -1;
    logic              ovf_prev      = 1'b0;
    int                last_rise_cyc = -1;
    int                pulse_idx     = -1;

    int wave_hi[$];
    int wave_lo[$];

    period_meter #(
        .WIDE_N    (WIDE_N),
        .AVG_SHIFT (AVG_SHIFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_i    (sig_i),
        .start_i  (start_i),
        .period_o (period_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            valid_val = period_o;
        end
        if (ovf_o && !ovf_prev) ovf_cyc = cyc;
        ovf_prev = ovf_o;
    end

    // Reference: floor of the mean of (period - 1) over the first NAVG periods
    function automatic logic [WIDE_N-1:0] model_result();
        longint sum = 0;
        for (int i = 0; i < NAVG; i++) sum += longint'(wave_hi[i] + wave_lo[i] - 1);
        return WIDE_N'(sum / NAVG);
    endfunction

    task automatic set_wave(input int hi, input int lo, input int n);
        wave_hi.delete();
        wave_lo.delete();
        for (int i = 0; i < n; i++) begin
            wave_hi.push_back(hi);
            wave_lo.push_back(lo);
        end
    endtask

    task automatic play_wave();
        for (int i = 0; i < wave_hi.size(); i++) begin
            @(negedge clk);
            sig_i         = 1'b1;
            last_rise_cyc = cyc;
            pulse_idx     = i;
            repeat (wave_hi[i] - 1) @(negedge clk);
            @(negedge clk);
            sig_i = 1'b0;
            repeat (wave_lo[i] - 1) @(negedge clk);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_measure(output int dvalid);
        int v0;
        v0 = valid_cnt;
        do_start();
        play_wave();
        repeat (10) @(negedge clk);
        dvalid = valid_cnt - v0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({period_o, valid_o, busy_o, ovf_o} !== '0) begin
            miscompares++;
            $display("FAIL reset: period=%0d valid=%b busy=%b ovf=%b, required all 0",
                     period_o, valid_o, busy_o, ovf_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0;
        set_wave(5, 5, NAVG + 1);
        v0 = valid_cnt;
        do_start();
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: busy=%b, required 1", busy_o);
        end
        play_wave();
        repeat (10) @(negedge clk);
        vectors++;
        if (valid_cnt - v0 !== 1 || period_o !== 12'd9 || valid_val !== 12'd9) begin
            miscompares++;
            $display("FAIL basic_result: pulses=%0d period=%0d, required 1 and 9",
                     valid_cnt - v0, period_o);
        end
        vectors++;
        if (ovf_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_flags: ovf=%b busy=%b, required 0 0", ovf_o, busy_o);
        end
        vectors++;
        if (valid_cyc !== last_rise_cyc + 4) begin
            miscompares++;
            $display("FAIL basic_latency: valid %0d cycles after last rise drive, required 4",
                     valid_cyc - last_rise_cyc);
        end
    endtask

    task automatic test_alternate();
        int dv;
        wave_hi = '{5, 5, 5, 5, 5};
        wave_lo = '{5, 6, 5, 6, 5};
        run_measure(dv);
        vectors++;
        if (dv !== 1 || period_o !== 12'd9) begin
            miscompares++;
            $display("FAIL alternate: pulses=%0d period=%0d, required 1 and 9", dv, period_o);
        end
    endtask

    task automatic test_pulse25();
        int dv;
        set_wave(2, 23, NAVG + 1);
        run_measure(dv);
        vectors++;
        if (dv !== 1 || period_o !== 12'd24) begin
            miscompares++;
            $display("FAIL pulse25: pulses=%0d period=%0d, required 1 and 24", dv, period_o);
        end
    endtask

    task automatic test_bounds();
        int dv;
        set_wave(2, 2, NAVG + 1);
        run_measure(dv);
        vectors++;
        if (dv !== 1 || period_o !== 12'd3) begin
            miscompares++;
            $display("FAIL min_period: pulses=%0d period=%0d, required 1 and 3", dv, period_o);
        end
        set_wave(2048, 2048, NAVG);
        wave_hi.push_back(2);
        wave_lo.push_back(8);
        run_measure(dv);
        vectors++;
        if (dv !== 1 || period_o !== 12'd4095 || ovf_o !== 1'b0) begin
            miscompares++;
            $display("FAIL max_period: pulses=%0d period=%0d ovf=%b, required 1 4095 0",
                     dv, period_o, ovf_o);
        end
    endtask

    task automatic test_random();
        int dv;
        int p;
        int hi;
        logic [WIDE_N-1:0] exp;
        for (int it = 0; it < 10; it++) begin
            wave_hi.delete();
            wave_lo.delete();
            for (int i = 0; i <= NAVG; i++) begin
                p  = int'($urandom_range(40, 4));
                hi = int'($urandom_range(p - 2, 2));
                wave_hi.push_back(hi);
                wave_lo.push_back(p - hi);
            end
            exp = model_result();
            run_measure(dv);
            vectors++;
            if (dv !== 1 || period_o !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]: pulses=%0d period=%0d, required 1 and %0d",
                         it, dv, period_o, exp);
            end
        end
    endtask

    task automatic test_timeout();
        int v0;
        int c;
        int n;
        int dv;
        set_wave(3, 1, 1);
        v0 = valid_cnt;
        do_start();
        play_wave();
        c = last_rise_cyc;
        for (n = 0; n < 4300 && !ovf_o; n++) @(negedge clk);
        vectors++;
        if (ovf_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_wait: ovf=%b after %0d cycles, required 1", ovf_o, n);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (ovf_cyc !== c + 4099) begin
            miscompares++;
            $display("FAIL timeout_time: ovf rose %0d cycles after rise drive, required 4099",
                     ovf_cyc - c);
        end
        vectors++;
        if (valid_cnt !== v0 || busy_o !== 1'b0 || period_o === 12'd0) begin
            miscompares++;
            $display("FAIL timeout_flags: pulses=%0d busy=%b period=%0d, required 0 0 held",
                     valid_cnt - v0, busy_o, period_o);
        end
        do_start();
        vectors++;
        if (ovf_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_clear: ovf=%b busy=%b, required 0 1", ovf_o, busy_o);
        end
        set_wave(6, 6, NAVG + 1);
        v0 = valid_cnt;
        play_wave();
        repeat (10) @(negedge clk);
        dv = valid_cnt - v0;
        vectors++;
        if (dv !== 1 || period_o !== 12'd11) begin
            miscompares++;
            $display("FAIL timeout_recover: pulses=%0d period=%0d, required 1 and 11",
                     dv, period_o);
        end
    endtask

    task automatic test_ignore_start();
        int v0;
        set_wave(7, 7, NAVG + 1);
        v0        = valid_cnt;
        pulse_idx = -1;
        do_start();
        fork
            play_wave();
            begin
                repeat (25) @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                for (int n = 0; n < 1000 && !(pulse_idx == NAVG && cyc == last_rise_cyc + 3);
                     n++) @(negedge clk);
                // lands in the DONE cycle
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        vectors++;
        if (valid_cnt - v0 !== 1 || period_o !== 12'd13 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start: pulses=%0d period=%0d busy=%b, required 1 13 0",
                     valid_cnt - v0, period_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        int dv;
        set_wave(8, 8, 2);
        v0 = valid_cnt;
        do_start();
        play_wave();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({period_o, valid_o, busy_o, ovf_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: period=%0d valid=%b busy=%b ovf=%b, required all 0",
                     period_o, valid_o, busy_o, ovf_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (valid_cnt !== v0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: pulses=%0d busy=%b, required 0 0",
                     valid_cnt - v0, busy_o);
        end
        set_wave(8, 8, NAVG + 1);
        run_measure(dv);
        vectors++;
        if (dv !== 1 || period_o !== 12'd15) begin
            miscompares++;
            $display("FAIL reset_mid_fresh: pulses=%0d period=%0d, required 1 and 15",
                     dv, period_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_pulse25();
        test_bounds();
        test_random();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
